// File: rtl/aes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_pkg                                                      |
// | Description : Shared state encoding and sizing constants for the AES round |
// |               sequencer and its helpers.                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package aes_pkg;

    localparam int BLK_W    = 128;
    localparam int NR_128   = 10;
    localparam int NR_192   = 12;
    localparam int NR_256   = 14;
    localparam int RK_IDX_W = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARK0 = 3'd1,
        S_SUB  = 3'd2,
        S_MIX  = 3'd3,
        S_ARK  = 3'd4,
        S_LSUB = 3'd5,
        S_LARK = 3'd6,
        S_DONE = 3'd7
    } aes_state_e;

    // Every state except IDLE and DONE waits on an engine done.
    function automatic logic is_wait_state(input aes_state_e s);
        return (s != S_IDLE) && (s != S_DONE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_stage_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_stage_watchdog                                           |
// | Description : Per-stage cycle counter; expire_o flags the last permitted   |
// |               cycle of a wait stage. TIMEOUT of 0 disables it.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aes_stage_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    generate
        if (TIMEOUT == 0) begin : g_wd_off
            assign expire_o = 1'b0;
        end else begin : g_wd_on
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr_i) begin
                    cnt_d = '0;
                end else if (en_i) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // Fires when this cycle would bring the count up to TIMEOUT.
            assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/aes_round_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : aes_round_seq                                                |
// | Description : AES round sequencer driving the AddRoundKey, SubShift and    |
// |               MixColumns engines via enable/done handshakes.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module aes_round_seq #(
    parameter int NR      = aes_pkg::NR_128,
    parameter int TIMEOUT = 1024,
    parameter int BLK_W   = aes_pkg::BLK_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [BLK_W-1:0]             pt_in,
    output logic                         busy,
    output logic [BLK_W-1:0]             ct_out,
    output logic                         ct_valid,
    output logic                         error,
    output logic [aes_pkg::RK_IDX_W-1:0] rk_idx,
    output logic                         add_en,
    output logic                         add_sel,
    output logic [BLK_W-1:0]             add_b,
    input  logic                         add_done,
    input  logic [BLK_W-1:0]             add_out,
    output logic                         ss_en,
    input  logic                         ss_done,
    output logic                         mc_en,
    input  logic                         mc_done,
    input  logic [BLK_W-1:0]             mc_out
);
    import aes_pkg::*;

    generate
        if (!(NR == NR_128 || NR == NR_192 || NR == NR_256)) begin : g_bad_nr
            $error("aes_round_seq: NR must be 10, 12 or 14");
        end
        if (BLK_W != 128) begin : g_bad_blk
            $error("aes_round_seq: BLK_W must be 128");
        end
    endgenerate

    localparam logic [RK_IDX_W-1:0] NR_IDX = RK_IDX_W'(NR);

    aes_state_e          state_q, state_d;
    logic [RK_IDX_W-1:0] r_q, r_d;
    logic [BLK_W-1:0]    add_b_q, add_b_d;
    logic [BLK_W-1:0]    ct_q, ct_d;
    logic                error_q, error_d;
    logic                wd_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            add_b_q <= '0;
            ct_q    <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            add_b_q <= add_b_d;
            ct_q    <= ct_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        add_b_d = add_b_q;
        ct_d    = ct_q;
        error_d = 1'b0;

        case (state_q)
            S_IDLE: if (start) begin
                add_b_d = pt_in;
                r_d     = '0;
                state_d = S_ARK0;
            end
            S_ARK0: if (add_done) begin
                r_d     = RK_IDX_W'(1);
                state_d = (NR_IDX == RK_IDX_W'(1)) ? S_LSUB : S_SUB;
            end
            S_SUB: if (ss_done) begin
                state_d = S_MIX;
            end
            S_MIX: if (mc_done) begin
                add_b_d = mc_out;
                state_d = S_ARK;
            end
            S_ARK: if (add_done) begin
                r_d     = r_q + 1'b1;
                state_d = (r_d == NR_IDX) ? S_LSUB : S_SUB;
            end
            S_LSUB: if (ss_done) begin
                state_d = S_LARK;
            end
            S_LARK: if (add_done) begin
                ct_d    = add_out;
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A done on the final permitted cycle still wins over the watchdog.
        if (wd_expire && (state_d == state_q)) begin
            state_d = S_IDLE;
            error_d = 1'b1;
        end
    end

    aes_stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (state_d != state_q),
        .en_i     (is_wait_state(state_q)),
        .expire_o (wd_expire)
    );

    always_comb begin
        rk_idx = '0;
        case (state_q)
            S_ARK0, S_ARK: rk_idx = r_q;
            S_LARK:        rk_idx = NR_IDX;
            default:       rk_idx = '0;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign ct_valid = (state_q == S_DONE);
    assign error    = error_q;
    assign ct_out   = ct_q;
    assign add_b    = add_b_q;
    assign add_en   = (state_q == S_ARK0) || (state_q == S_ARK) || (state_q == S_LARK);
    assign add_sel  = (state_q == S_LARK);
    assign ss_en    = (state_q == S_SUB) || (state_q == S_LSUB);
    assign mc_en    = (state_q == S_MIX);

endmodule
`default_nettype wire

// File: tb/tb_aes_round_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_aes_round_seq                                             |
// | Description : Directed bench: four sequencers (NR 10/12/14 and a 16-cycle  |
// |               watchdog) driving behavioural AES engines.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_aes_round_seq;

    localparam int NI = 4;
    localparam int LA = 1;
    localparam int LS = 20;
    localparam int LM = 4;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NI-1:0] start, busy, ct_valid, error, add_en, add_sel, add_done;
    logic [NI-1:0] ss_en, ss_done, mc_en, mc_done;
    logic [127:0]  pt_in [NI];
    logic [127:0]  ct_out [NI];
    logic [127:0]  add_b [NI];
    logic [127:0]  add_out [NI];
    logic [127:0]  mc_out [NI];
    logic [3:0]    rk_idx [NI];
    logic          inj_add, inj_mc;

    logic [7:0]    sbox_t [256];
    logic [127:0]  rk [15];
    int            errs = 0;
    int            checks = 0;
    int            cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox_t[s[127-8*(r+4*((c+r)%4)) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural engines: done arrives L cycles after the enable rises.
    for (genvar g = 0; g < NI; g++) begin : g_eng
        localparam int NRG = (g == 1) ? 12 : (g == 2) ? 14 : 10;
        int           ca = 0, cs = 0, cm = 0;
        logic [127:0] ark_q, ss_q, rkv;
        int           n_ctv = 0, n_err = 0, n_mc = 0, n_add = 0, bad = 0, ss_at = 0, exp_rk = 0;
        logic         pa = 1'b0, pm = 1'b0;

        assign rkv         = rk[rk_idx[g]];
        assign add_done[g] = (add_en[g] && ca == LA) || (g == 0 && inj_add);
        assign ss_done[g]  = ss_en[g] && cs == LS && g != 3;
        assign mc_done[g]  = (mc_en[g] && cm == LM) || (g == 0 && inj_mc);
        assign add_out[g]  = (add_sel[g] ? ss_q : add_b[g]) ^ rkv;
        assign mc_out[g]   = mix(ss_q);

        always @(posedge clk) begin
            ca <= add_en[g] ? ca + 1 : 0;
            cs <= ss_en[g]  ? cs + 1 : 0;
            cm <= mc_en[g]  ? cm + 1 : 0;
            if (add_en[g] && ca == LA && !add_sel[g]) ark_q <= add_b[g] ^ rkv;
            if (ss_en[g] && cs == LS) ss_q <= sub_shift(ark_q);
        end

        always @(negedge clk) begin
            pa <= add_en[g];
            pm <= mc_en[g];
            if (ct_valid[g]) n_ctv <= n_ctv + 1;
            if (error[g]) n_err <= n_err + 1;
            if (mc_en[g] && !pm) n_mc <= n_mc + 1;
            if (ss_en[g] && ss_at == 0) ss_at <= cyc;
            if (!busy[g]) begin
                exp_rk <= 0;
            end else if (add_en[g] && !pa) begin
                n_add  <= n_add + 1;
                exp_rk <= exp_rk + 1;
            end
            bad <= bad + int'(add_en[g] && !pa && rk_idx[g] != exp_rk[3:0])
                       + int'(add_sel[g] && !(add_en[g] && rk_idx[g] == 4'(NRG)))
                       + int'(mc_en[g] && (add_en[g] || ss_en[g] || add_sel[g]));
        end

        aes_round_seq #(
            .NR      (NRG),
            .TIMEOUT ((g == 3) ? 16 : 1024),
            .BLK_W   (128)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start[g]),
            .pt_in    (pt_in[g]),
            .busy     (busy[g]),
            .ct_out   (ct_out[g]),
            .ct_valid (ct_valid[g]),
            .error    (error[g]),
            .rk_idx   (rk_idx[g]),
            .add_en   (add_en[g]),
            .add_sel  (add_sel[g]),
            .add_b    (add_b[g]),
            .add_done (add_done[g]),
            .add_out  (add_out[g]),
            .ss_en    (ss_en[g]),
            .ss_done  (ss_done[g]),
            .mc_en    (mc_en[g]),
            .mc_done  (mc_done[g]),
            .mc_out   (mc_out[g])
        );
    end

    initial begin
        logic [7:0]  inv;
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        int          k, nm;
        logic        pmx;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 15; r++)
            rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;

        start   = '0;
        inj_add = 1'b0;
        inj_mc  = 1'b0;
        for (int i = 0; i < NI; i++) pt_in[i] = PT;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 4'h0);
        chk("rst_ct_valid", ct_valid, 4'h0);
        chk("rst_error", error, 4'h0);
        chk("rst_enables", {add_en, ss_en, mc_en}, 12'h000);
        chk("rst_ct_out", ct_out[0], 128'h0);
        chk("rst_add_b", add_b[0], 128'h0);
        chk("rst_rk_idx", rk_idx[0], 4'h0);
        chk("rst_add_sel", add_sel, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        // All four start together; instance 0 keeps start asserted
        @(negedge clk);
        start = 4'hf;
        k = cyc + 1;
        @(negedge clk);
        start = 4'h1;
        chk("ark0_busy", busy, 4'hf);
        chk("ark0_add_en", add_en, 4'hf);
        chk("ark0_add_b", add_b[0], PT);
        chk("ark0_rk_idx", rk_idx[0], 4'h0);

        // Spurious dones while instance 0 sits in SUB
        for (int i = 0; i < 20 && !ss_en[0]; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        inj_add = 1'b1;
        inj_mc  = 1'b1;
        repeat (2) @(negedge clk);
        inj_add = 1'b0;
        inj_mc  = 1'b0;

        // Watchdog on instance 3 (ss_done never arrives)
        for (int i = 0; i < 100 && !error[3]; i++) @(negedge clk);
        chk("wd_error_seen", error[3], 1'b1);
        chk("wd_delay", cyc - g_eng[3].ss_at, 16);
        chk("wd_enables", {add_en[3], ss_en[3], mc_en[3]}, 3'b000);
        chk("wd_busy", busy[3], 1'b0);
        @(negedge clk);
        chk("wd_error_pulse", error[3], 1'b0);
        chk("wd_enables_after", {add_en[3], ss_en[3], mc_en[3], busy[3]}, 4'b0000);

        // NR=10 with FIPS-197 C.1
        for (int i = 0; i < 600 && !ct_valid[0]; i++) @(negedge clk);
        chk("nr10_ctv_seen", ct_valid[0], 1'b1);
        chk("nr10_ctv_cycle", cyc + 1 - k, 278);
        chk("nr10_ct_out", ct_out[0], CT);
        @(negedge clk);
        chk("nr10_ctv_pulse", ct_valid[0], 1'b0);
        chk("idle_gap", busy[0], 1'b0);
        @(negedge clk);
        chk("back2back_accept", busy[0], 1'b1);
        start = 4'h0;

        for (int i = 0; i < 600 && !ct_valid[1]; i++) @(negedge clk);
        chk("nr12_ctv_cycle", cyc + 1 - k, 334);
        for (int i = 0; i < 600 && !ct_valid[2]; i++) @(negedge clk);
        chk("nr14_ctv_cycle", cyc + 1 - k, 390);
        for (int i = 0; i < 600 && !ct_valid[0]; i++) @(negedge clk);
        chk("job2_ctv_cycle", cyc + 1 - k, 557);
        chk("job2_ct_out", ct_out[0], CT);
        repeat (3) @(negedge clk);

        chk("nr10_n_ctv", g_eng[0].n_ctv, 2);
        chk("nr10_n_mc", g_eng[0].n_mc, 18);
        chk("nr10_n_add", g_eng[0].n_add, 22);
        chk("nr12_counts", {8'(g_eng[1].n_ctv), 8'(g_eng[1].n_mc), 8'(g_eng[1].n_add)}, {8'd1, 8'd11, 8'd13});
        chk("nr14_counts", {8'(g_eng[2].n_ctv), 8'(g_eng[2].n_mc), 8'(g_eng[2].n_add)}, {8'd1, 8'd13, 8'd15});
        chk("wd_no_ctv", g_eng[3].n_ctv, 0);
        chk("wd_n_err", g_eng[3].n_err, 1);
        chk("wd_ct_out", ct_out[3], 128'h0);
        chk("seq_bad", g_eng[0].bad + g_eng[1].bad + g_eng[2].bad + g_eng[3].bad, 0);

        // Reset during MIX of round 5
        @(negedge clk);
        start = 4'h1;
        @(negedge clk);
        start = 4'h0;
        nm  = 0;
        pmx = 1'b0;
        for (int i = 0; i < 400 && nm < 5; i++) begin
            @(negedge clk);
            if (mc_en[0] && !pmx) nm++;
            pmx = mc_en[0];
        end
        chk("mix5_reached", {mc_en[0], rk_idx[0]}, 5'h10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy[0], 1'b0);
        chk("abort_outputs", {ct_valid[0], error[0], add_en[0], ss_en[0], mc_en[0], add_sel[0], rk_idx[0]}, 10'h000);
        chk("abort_ct_out", ct_out[0], 128'h0);
        chk("abort_add_b", add_b[0], 128'h0);

        @(negedge clk);
        start = 4'h1;
        k = cyc + 1;
        @(negedge clk);
        start = 4'h0;
        for (int i = 0; i < 600 && !ct_valid[0]; i++) @(negedge clk);
        chk("fresh_ctv_cycle", cyc + 1 - k, 278);
        chk("fresh_ct_out", ct_out[0], CT);
        repeat (3) @(negedge clk);
        chk("fresh_n_ctv", g_eng[0].n_ctv, 3);
        chk("final_seq_bad", g_eng[0].bad, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
